// File: rtl/bin_to_bcd_serial_if.sv
// ---------------------------------------------------------------------------
// bin_to_bcd_serial_if
// Handshake bundle for the serial binary-to-BCD converter.
//   in_valid / in_ready / bin_in    : request side (producer -> converter)
//   out_valid / out_ready           : result side (converter -> consumer)
//   bcd / overflow                  : registered result, digit0 in bcd[3:0]
//   busy                            : converter is in SHIFT or DONE
// Modports:
//   master : the producer/consumer environment driving the converter
//   slave  : the converter itself
// ---------------------------------------------------------------------------
interface bin_to_bcd_serial_if #(
    parameter int BIN_WIDTH = 8,
    parameter int DIGITS    = 3
);
    logic                   in_valid;
    logic                   in_ready;
    logic [BIN_WIDTH-1:0]   bin_in;
    logic                   out_valid;
    logic                   out_ready;
    logic [4*DIGITS-1:0]    bcd;
    logic                   overflow;
    logic                   busy;

    modport master (
        output in_valid, bin_in, out_ready,
        input  in_ready, out_valid, bcd, overflow, busy
    );

    modport slave (
        input  in_valid, bin_in, out_ready,
        output in_ready, out_valid, bcd, overflow, busy
    );
endinterface

// File: rtl/bin_to_bcd_serial.sv
// ---------------------------------------------------------------------------
// bin_to_bcd_serial
// Sequential double-dabble converter: one unsigned BIN_WIDTH-bit value in,
// DIGITS packed BCD digits out, one conversion in flight at a time.
// Ports:
//   clk    : system clock, rising edge
//   reset  : synchronous, active-high
//   bus    : bin_to_bcd_serial_if.slave (valid/ready on both sides,
//            registered bcd/overflow result, busy flag)
// Timing: out_valid rises BIN_WIDTH edges after the accepting edge; with
// in_valid and out_ready held high one value is accepted every
// BIN_WIDTH+2 cycles. in_ready/out_valid/busy decode the state register
// only, so there is no combinational path from the handshake inputs.
// ---------------------------------------------------------------------------
module bin_to_bcd_serial #(
    parameter int BIN_WIDTH = 8,
    parameter int DIGITS    = 3
) (
    input  logic              clk,
    input  logic              reset,
    bin_to_bcd_serial_if.slave bus
);
    localparam int BCD_W = 4 * DIGITS;
    localparam int SR_W  = BCD_W + BIN_WIDTH;
    localparam int CNT_W = $clog2(BIN_WIDTH + 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t               state_q,    state_d;
    logic [BIN_WIDTH-1:0] bin_q,      bin_d;
    logic [BCD_W-1:0]     work_q,     work_d;
    logic                 ovf_acc_q,  ovf_acc_d;
    logic [CNT_W-1:0]     cnt_q,      cnt_d;
    logic [BCD_W-1:0]     bcd_q,      bcd_d;
    logic                 overflow_q, overflow_d;

    logic [BCD_W-1:0]     work_adj;
    logic [SR_W-1:0]      sr_pre;
    logic [SR_W-1:0]      sr_post;
    logic                 carry_out;

    // Per-digit "add 3 if >= 5" correction. Each digit wraps modulo 16 on
    // its own; the subsequent shift is what moves bits between digits.
    generate
        for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
            assign work_adj[4*gi +: 4] = (work_q[4*gi +: 4] >= 4'd5)
                                       ? work_q[4*gi +: 4] + 4'd3
                                       : work_q[4*gi +: 4];
        end
    endgenerate

    // The bit leaving the top digit is weight 10^DIGITS or more; any such
    // bit means the input did not fit, and the kept digits are value mod
    // 10^DIGITS.
    assign sr_pre    = {work_adj, bin_q};
    assign sr_post   = {sr_pre[SR_W-2:0], 1'b0};
    assign carry_out = sr_pre[SR_W-1];

    always_comb begin
        state_d    = state_q;
        bin_d      = bin_q;
        work_d     = work_q;
        ovf_acc_d  = ovf_acc_q;
        cnt_d      = cnt_q;
        bcd_d      = bcd_q;
        overflow_d = overflow_q;

        case (state_q)
            S_IDLE: begin
                if (bus.in_valid) begin
                    bin_d     = bus.bin_in;
                    work_d    = '0;
                    ovf_acc_d = 1'b0;
                    cnt_d     = CNT_W'(BIN_WIDTH);
                    state_d   = S_SHIFT;
                end
            end
            S_SHIFT: begin
                work_d    = sr_post[SR_W-1:BIN_WIDTH];
                bin_d     = sr_post[BIN_WIDTH-1:0];
                ovf_acc_d = ovf_acc_q | carry_out;
                cnt_d     = cnt_q - CNT_W'(1);
                // Last shift: publish the fully shifted work register,
                // including this edge's carry, as the visible result.
                if (cnt_q == CNT_W'(1)) begin
                    bcd_d      = sr_post[SR_W-1:BIN_WIDTH];
                    overflow_d = ovf_acc_q | carry_out;
                    state_d    = S_DONE;
                end
            end
            S_DONE: begin
                if (bus.out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            bin_q      <= '0;
            work_q     <= '0;
            ovf_acc_q  <= 1'b0;
            cnt_q      <= '0;
            bcd_q      <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            bin_q      <= bin_d;
            work_q     <= work_d;
            ovf_acc_q  <= ovf_acc_d;
            cnt_q      <= cnt_d;
            bcd_q      <= bcd_d;
            overflow_q <= overflow_d;
        end
    end

    assign bus.in_ready  = (state_q == S_IDLE);
    assign bus.out_valid = (state_q == S_DONE);
    assign bus.busy      = (state_q != S_IDLE);
    assign bus.bcd       = bcd_q;
    assign bus.overflow  = overflow_q;

endmodule

// File: tb/tb_bin_to_bcd_serial.sv
// ---------------------------------------------------------------------------
// tb_bin_to_bcd_serial
// Directed bench for bin_to_bcd_serial: a 3-digit instance (main) and a
// 2-digit instance (overflow behaviour). Expected results come from a
// decimal divide/modulo model and travel through scoreboard queues from
// the point the value is driven to the point the result appears.
// Inputs are driven and outputs sampled on the falling clock edge.
// ---------------------------------------------------------------------------
module tb_bin_to_bcd_serial;
    typedef struct packed {
        logic [7:0]  val;
        logic [11:0] bcd;
        logic        ovf;
    } exp_t;

    logic clk;
    logic reset;

    int checks = 0;
    int errors = 0;

    exp_t q3[$];
    exp_t q2[$];

    int fib[14] = '{0, 1, 1, 2, 3, 5, 8, 13, 21, 34, 55, 89, 144, 233};

    bin_to_bcd_serial_if #(.BIN_WIDTH(8), .DIGITS(3)) b  ();
    bin_to_bcd_serial_if #(.BIN_WIDTH(8), .DIGITS(2)) b2 ();

    bin_to_bcd_serial #(.BIN_WIDTH(8), .DIGITS(3)) u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (b)
    );

    bin_to_bcd_serial #(.BIN_WIDTH(8), .DIGITS(2)) u_dut2 (
        .clk   (clk),
        .reset (reset),
        .bus   (b2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: decimal digits by division, overflow if anything remains.
    function automatic exp_t make_exp(input int v, input int digits);
        exp_t e;
        int   t;
        t     = v;
        e.val = 8'(v);
        e.bcd = '0;
        for (int i = 0; i < digits; i++) begin
            e.bcd[4*i +: 4] = 4'(t % 10);
            t = t / 10;
        end
        e.ovf = (t != 0);
        return e;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Offer one value to the 3-digit DUT; the accepting edge is the next
    // rising edge. Returns on the falling edge just after acceptance.
    task automatic send(input int v);
        int n;
        n = 0;
        while (!b.in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("in_ready_before_send", 32'(b.in_ready), 32'd1);
        b.in_valid = 1'b1;
        b.bin_in   = 8'(v);
        q3.push_back(make_exp(v, 3));
        @(negedge clk);
        b.in_valid = 1'b0;
    endtask

    // Wait for a result, compare it against the scoreboard, optionally hold
    // it for 'hold' cycles with out_ready low, then release it.
    task automatic recv(input string tag, input int hold, output int lat);
        exp_t e;
        lat = 0;
        while (!b.out_valid && lat < 50) begin
            @(negedge clk);
            lat++;
        end
        check({tag, "_out_valid"}, 32'(b.out_valid), 32'd1);
        if (q3.size() == 0) begin
            check({tag, "_scoreboard_empty"}, 32'(q3.size()), 32'd1);
        end else begin
            e = q3.pop_front();
            $display("xfer %s: bin=%0d bcd=%h ovf=%b latency=%0d", tag, e.val, b.bcd, b.overflow, lat);
            check({tag, "_bcd"}, 32'(b.bcd), 32'(e.bcd));
            check({tag, "_ovf"}, 32'(b.overflow), 32'(e.ovf));
            for (int i = 0; i < hold; i++) begin
                b.in_valid = (i % 2 == 0);
                b.bin_in   = 8'd77;
                @(negedge clk);
                check({tag, "_hold_out_valid"}, 32'(b.out_valid), 32'd1);
                check({tag, "_hold_in_ready"}, 32'(b.in_ready), 32'd0);
                check({tag, "_hold_bcd"}, 32'(b.bcd), 32'(e.bcd));
            end
            b.in_valid = 1'b0;
        end
        b.out_ready = 1'b1;
        @(negedge clk);
        b.out_ready = 1'b0;
        check({tag, "_released_out_valid"}, 32'(b.out_valid), 32'd0);
        check({tag, "_released_in_ready"}, 32'(b.in_ready), 32'd1);
    endtask

    // Full round trip on the 2-digit DUT.
    task automatic conv2(input int v);
        exp_t e;
        int   n;
        n = 0;
        while (!b2.in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        b2.in_valid = 1'b1;
        b2.bin_in   = 8'(v);
        q2.push_back(make_exp(v, 2));
        @(negedge clk);
        b2.in_valid = 1'b0;
        n = 0;
        while (!b2.out_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("d2_out_valid", 32'(b2.out_valid), 32'd1);
        e = q2.pop_front();
        $display("xfer d2: bin=%0d bcd=%h ovf=%b", e.val, b2.bcd, b2.overflow);
        check("d2_bcd", 32'(b2.bcd), 32'(e.bcd[7:0]));
        check("d2_ovf", 32'(b2.overflow), 32'(e.ovf));
        b2.out_ready = 1'b1;
        @(negedge clk);
        b2.out_ready = 1'b0;
    endtask

    initial begin
        int   lat;
        int   idx;
        int   got;
        int   cyc;
        int   last_acc;
        exp_t e;

        reset        = 1'b1;
        b.in_valid   = 1'b0;
        b.bin_in     = '0;
        b.out_ready  = 1'b0;
        b2.in_valid  = 1'b0;
        b2.bin_in    = '0;
        b2.out_ready = 1'b0;
        repeat (3) @(negedge clk);

        // Reset state (in_valid was low throughout)
        check("rst_in_ready", 32'(b.in_ready), 32'd1);
        check("rst_out_valid", 32'(b.out_valid), 32'd0);
        check("rst_busy", 32'(b.busy), 32'd0);
        check("rst_bcd", 32'(b.bcd), 32'd0);
        check("rst_ovf", 32'(b.overflow), 32'd0);
        reset = 1'b0;
        @(negedge clk);

        // 1: zero, with exact latency
        send(0);
        check("t1_busy_shift", 32'(b.busy), 32'd1);
        recv("t1_zero", 0, lat);
        check("t1_latency", 32'(lat), 32'd8);

        // 2: assorted values including the 8-bit maximum
        send(233); recv("t2_233", 0, lat);
        check("t2_latency", 32'(lat), 32'd8);
        send(144); recv("t2_144", 0, lat);
        send(255); recv("t2_255", 0, lat);
        send(9);   recv("t2_9", 0, lat);
        send(100); recv("t2_100", 0, lat);

        // 3: two-digit build, overflow and mod-100 result
        conv2(144);
        conv2(99);
        conv2(100);
        conv2(255);

        // 4: result held with out_ready low, in_valid pulses ignored
        send(201);
        recv("t4_hold", 5, lat);

        // 5: reset in the middle of a conversion discards it
        send(233);
        repeat (3) @(negedge clk);
        check("t5_busy_before_reset", 32'(b.busy), 32'd1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        void'(q3.pop_back());
        check("t5_out_valid", 32'(b.out_valid), 32'd0);
        check("t5_bcd", 32'(b.bcd), 32'd0);
        check("t5_in_ready", 32'(b.in_ready), 32'd1);
        check("t5_busy", 32'(b.busy), 32'd0);
        send(89);
        recv("t5_89", 0, lat);
        check("t5_latency", 32'(lat), 32'd8);

        // 6: Fibonacci stream with in_valid/out_ready held high
        idx         = 0;
        got         = 0;
        cyc         = 0;
        last_acc    = -1;
        b.out_ready = 1'b1;
        while (got < 14 && cyc < 400) begin
            if (b.out_valid) begin
                if (q3.size() == 0) begin
                    check("t6_unexpected_output", 32'(q3.size()), 32'd1);
                end else begin
                    e = q3.pop_front();
                    $display("xfer t6: bin=%0d bcd=%h ovf=%b", e.val, b.bcd, b.overflow);
                    check("t6_bcd", 32'(b.bcd), 32'(e.bcd));
                    check("t6_ovf", 32'(b.overflow), 32'(e.ovf));
                end
                got++;
            end
            if (b.in_ready) begin
                if (last_acc >= 0) begin
                    check("t6_accept_interval", 32'(cyc - last_acc), 32'd10);
                end
                last_acc = cyc;
                if (idx < 14) begin
                    b.in_valid = 1'b1;
                    b.bin_in   = 8'(fib[idx]);
                    q3.push_back(make_exp(fib[idx], 3));
                    idx++;
                end else begin
                    b.in_valid = 1'b0;
                end
            end
            @(negedge clk);
            cyc++;
        end
        b.in_valid  = 1'b0;
        b.out_ready = 1'b0;
        check("t6_terms_sent", 32'(idx), 32'd14);
        check("t6_terms_received", 32'(got), 32'd14);
        check("t6_scoreboard_drained", 32'(q3.size()), 32'd0);
        @(negedge clk);
        check("t6_idle_after", 32'(b.in_ready), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
